// File: rtl/aes_round_sequencer.sv
// AES-128 round sequencer: expands/stores round keys, then steps an external
// aesUnit through whitening and ten rounds for one block per request.
//   clk, reset(sync, active-high)       clock / reset
//   start, encrypt, key, dataIn         request, sampled when ready=1
//   ready, done, dataOut                idle flag, result pulse, result block
//   aesA, aesB, aesKeyAssist,
//   aesEncryption, aesFinalRound        registered drive to aesUnit
//   aesResult                           combinational result from aesUnit
module aes_round_sequencer #(
  parameter int KEY_REUSE    = 1,
  parameter int ROUND_CYCLES = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         encrypt,
  input  logic [127:0] key,
  input  logic [127:0] dataIn,
  output logic         ready,
  output logic         done,
  output logic [127:0] dataOut,
  output logic [127:0] aesA,
  output logic [127:0] aesB,
  output logic         aesKeyAssist,
  output logic         aesEncryption,
  output logic         aesFinalRound,
  input  logic [127:0] aesResult
);

  typedef enum logic [2:0] {
    IDLE, KEYEXP, WHITEN, ROUND, DONE
  } state_e;

  localparam logic [1:0] CYC_LAST = 2'(ROUND_CYCLES - 1);

  state_e       fsm_q, fsm_d;
  logic         enc_q, enc_d;
  logic [127:0] st_q, st_d;
  logic [127:0] rk_q [11];
  logic [127:0] rk_d [11];
  logic         kv_q, kv_d;
  logic [127:0] skey_q, skey_d;
  logic [3:0]   r_q, r_d;
  logic [3:0]   i_q, i_d;
  logic [1:0]   cyc_q, cyc_d;
  logic         done_q, done_d;
  logic [127:0] dout_q, dout_d;
  logic [127:0] a_q, a_d;
  logic [127:0] b_q, b_d;
  logic         ka_q, ka_d;
  logic         ae_q, ae_d;
  logic         fin_q, fin_d;
  logic         hold;

  // aesUnit inputs stay put until the last hold cycle of an operation
  assign hold = (cyc_q != CYC_LAST);

  always_comb begin
    fsm_d  = fsm_q;
    enc_d  = enc_q;
    st_d   = st_q;
    rk_d   = rk_q;
    kv_d   = kv_q;
    skey_d = skey_q;
    r_d    = r_q;
    i_d    = i_q;
    cyc_d  = cyc_q;
    done_d = 1'b0;
    dout_d = dout_q;
    a_d    = '0;
    b_d    = '0;
    ka_d   = 1'b0;
    ae_d   = 1'b0;
    fin_d  = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        if (start) begin
          enc_d    = encrypt;
          rk_d[0]  = key;
          st_d     = dataIn;
          cyc_d    = '0;
          if ((KEY_REUSE != 0) && kv_q
              && (key == skey_q)) begin
            fsm_d = WHITEN;
          end else begin
            fsm_d = KEYEXP;
            kv_d  = 1'b0;
            r_d   = 4'd1;
            a_d   = key;
            b_d   = 128'd1;
            ka_d  = 1'b1;
          end
        end
      end
      KEYEXP: begin
        if (hold) begin
          cyc_d = cyc_q + 2'd1;
          a_d   = a_q;
          b_d   = b_q;
          ka_d  = 1'b1;
        end else begin
          rk_d[r_q] = aesResult;
          cyc_d     = '0;
          if (r_q == 4'd10) begin
            kv_d   = 1'b1;
            skey_d = rk_q[0];
            fsm_d  = WHITEN;
          end else begin
            r_d  = r_q + 4'd1;
            a_d  = aesResult;
            b_d  = 128'(r_q + 4'd1);
            ka_d = 1'b1;
          end
        end
      end
      WHITEN: begin
        st_d  = st_q ^ (enc_q ? rk_q[0] : rk_q[10]);
        i_d   = 4'd1;
        cyc_d = '0;
        fsm_d = ROUND;
        a_d   = st_d;
        b_d   = enc_q ? rk_q[1] : rk_q[9];
        ae_d  = enc_q;
      end
      ROUND: begin
        if (hold) begin
          cyc_d = cyc_q + 2'd1;
          a_d   = a_q;
          b_d   = b_q;
          ae_d  = ae_q;
          fin_d = fin_q;
        end else begin
          st_d  = aesResult;
          cyc_d = '0;
          if (i_q == 4'd10) begin
            fsm_d = DONE;
          end else begin
            i_d   = i_q + 4'd1;
            a_d   = aesResult;
            b_d   = enc_q ? rk_q[4'(i_q + 4'd1)]
                          : rk_q[4'(4'd9 - i_q)];
            ae_d  = enc_q;
            fin_d = (i_q == 4'd9);
          end
        end
      end
      DONE: begin
        done_d = 1'b1;
        dout_d = st_q;
        fsm_d  = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q  <= IDLE;
      enc_q  <= 1'b0;
      st_q   <= '0;
      rk_q   <= '{default: '0};
      kv_q   <= 1'b0;
      skey_q <= '0;
      r_q    <= '0;
      i_q    <= '0;
      cyc_q  <= '0;
      done_q <= 1'b0;
      dout_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      ka_q   <= 1'b0;
      ae_q   <= 1'b0;
      fin_q  <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      enc_q  <= enc_d;
      st_q   <= st_d;
      rk_q   <= rk_d;
      kv_q   <= kv_d;
      skey_q <= skey_d;
      r_q    <= r_d;
      i_q    <= i_d;
      cyc_q  <= cyc_d;
      done_q <= done_d;
      dout_q <= dout_d;
      a_q    <= a_d;
      b_q    <= b_d;
      ka_q   <= ka_d;
      ae_q   <= ae_d;
      fin_q  <= fin_d;
    end
  end

  assign ready         = (fsm_q == IDLE);
  assign done          = done_q;
  assign dataOut       = dout_q;
  assign aesA          = a_q;
  assign aesB          = b_q;
  assign aesKeyAssist  = ka_q;
  assign aesEncryption = ae_q;
  assign aesFinalRound = fin_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer with a behavioural aesUnit model
// attached to each instance (ROUND_CYCLES=1 and ROUND_CYCLES=3).
module tb_aes_round_sequencer;

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] R1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] R2 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic s1 = 1'b0;
  logic s3 = 1'b0;
  logic enc = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] din = '0;

  logic rdy1, dn1, ka1, ae1, fn1;
  logic rdy3, dn3, ka3, ae3, fn3;
  logic [127:0] do1, a1, b1, res1;
  logic [127:0] do3, a3, b3, res3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_round_sequencer #(.KEY_REUSE(1), .ROUND_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .start(s1), .encrypt(enc),
    .key(key), .dataIn(din), .ready(rdy1), .done(dn1),
    .dataOut(do1), .aesA(a1), .aesB(b1), .aesKeyAssist(ka1),
    .aesEncryption(ae1), .aesFinalRound(fn1), .aesResult(res1)
  );

  aes_round_sequencer #(.KEY_REUSE(1), .ROUND_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .start(s3), .encrypt(enc),
    .key(key), .dataIn(din), .ready(rdy3), .done(dn3),
    .dataOut(do3), .aesA(a3), .aesB(b3), .aesKeyAssist(ka3),
    .aesEncryption(ae3), .aesFinalRound(fn3), .aesResult(res3)
  );

  // ---- aesUnit model ----
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a,
                                    input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] x);
    if (x == 8'h00) return 8'h00;
    for (int y = 1; y < 256; y++)
      if (gm(x, 8'(y)) == 8'h01) return 8'(y);
    return 8'h00;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x,
                                      input int n);
    logic [15:0] d = {x, x};
    d = d >> (8 - n);
    return d[7:0];
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] i = ginv(x);
    return i ^ rotl(i, 1) ^ rotl(i, 2) ^ rotl(i, 3)
             ^ rotl(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isb(input logic [7:0] x);
    return ginv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] aes_op(
    input logic [127:0] a, input logic [127:0] b,
    input logic ka, input logic en, input logic fin);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] rc, x0, x1, x2, x3;
    logic [31:0] w, n0, n1, n2, n3;
    logic [127:0] o;
    if (ka) begin
      rc = 8'h01;
      for (int k = 1; k < int'(b[3:0]); k++) rc = xt(rc);
      w = {sb(a[23:16]), sb(a[15:8]), sb(a[7:0]), sb(a[31:24])};
      w = w ^ {rc, 24'h0};
      n0 = a[127:96] ^ w;
      n1 = a[95:64] ^ n0;
      n2 = a[63:32] ^ n1;
      n3 = a[31:0] ^ n2;
      return {n0, n1, n2, n3};
    end
    for (int k = 0; k < 16; k++) s[k] = a[127 - 8*k -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (en) t[r + 4*c] = sb(s[r + 4*((c + r) % 4)]);
        else    t[r + 4*c] = isb(s[r + 4*((c - r + 4) % 4)]);
    if (en && !fin)
      for (int c = 0; c < 4; c++) begin
        x0 = t[4*c]; x1 = t[4*c+1]; x2 = t[4*c+2]; x3 = t[4*c+3];
        t[4*c]   = gm(x0, 2) ^ gm(x1, 3) ^ x2 ^ x3;
        t[4*c+1] = x0 ^ gm(x1, 2) ^ gm(x2, 3) ^ x3;
        t[4*c+2] = x0 ^ x1 ^ gm(x2, 2) ^ gm(x3, 3);
        t[4*c+3] = gm(x0, 3) ^ x1 ^ x2 ^ gm(x3, 2);
      end
    for (int k = 0; k < 16; k++) o[127 - 8*k -: 8] = t[k];
    o = o ^ b;
    if (!en && !fin) begin
      for (int k = 0; k < 16; k++) t[k] = o[127 - 8*k -: 8];
      for (int c = 0; c < 4; c++) begin
        x0 = t[4*c]; x1 = t[4*c+1]; x2 = t[4*c+2]; x3 = t[4*c+3];
        t[4*c]   = gm(x0,14) ^ gm(x1,11) ^ gm(x2,13) ^ gm(x3, 9);
        t[4*c+1] = gm(x0, 9) ^ gm(x1,14) ^ gm(x2,11) ^ gm(x3,13);
        t[4*c+2] = gm(x0,13) ^ gm(x1, 9) ^ gm(x2,14) ^ gm(x3,11);
        t[4*c+3] = gm(x0,11) ^ gm(x1,13) ^ gm(x2, 9) ^ gm(x3,14);
      end
      for (int k = 0; k < 16; k++) o[127 - 8*k -: 8] = t[k];
    end
    return o;
  endfunction

  assign res1 = aes_op(a1, b1, ka1, ae1, fn1);
  assign res3 = aes_op(a3, b3, ka3, ae3, fn3);

  // ---- checking helpers ----
  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Returns the spec-style latency: done is seen just after edge T0+n,
  // so it is sampled high at edge T0+n+1. 0 means timeout.
  task automatic wait_done(input int sel, input int n0,
                           output int lat);
    lat = 0;
    for (int n = n0; n <= 300; n++) begin
      @(posedge clk); #1;
      if ((sel == 0) ? dn1 : dn3) begin
        lat = n + 1;
        break;
      end
    end
    if (lat == 0) $display("FAIL timeout waiting for done");
  endtask

  task automatic accept(input int sel, input logic [127:0] k,
                        input logic [127:0] d, input logic e);
    @(negedge clk);
    for (int n = 0; n < 100; n++) begin
      if ((sel == 0) ? rdy1 : rdy3) break;
      @(negedge clk);
    end
    key = k; din = d; enc = e;
    if (sel == 0) s1 = 1'b1; else s3 = 1'b1;
    @(posedge clk); #1;
    s1 = 1'b0; s3 = 1'b0;
    key = ~k; din = {$urandom, $urandom, $urandom, $urandom};
    enc = ~e;
  endtask

  task automatic run_op(input int sel, input logic [127:0] k,
                        input logic [127:0] d, input logic e,
                        output logic [127:0] out, output int lat);
    accept(sel, k, d, e);
    wait_done(sel, 1, lat);
    out = (sel == 0) ? do1 : do3;
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] din;
    logic         enc;
    logic [127:0] exp;
    int           lat;
  } vec_t;

  vec_t vt [4];

  initial begin
    logic [127:0] out;
    int lat;
    int dones;
    int first;
    logic rdy_at_done;
    logic seen2;

    vt[0] = '{K1, P1, 1'b1, C1, 23};
    vt[1] = '{K1, C1, 1'b0, P1, 13};
    vt[2] = '{K2, P2, 1'b1, C2, 23};
    vt[3] = '{K2, C2, 1'b0, P2, 13};

    repeat (3) @(posedge clk);
    #1;
    chk("rst ready", 128'(rdy1), 128'(1));
    chk("rst done", 128'(dn1), 128'(0));
    chk("rst dataOut", do1, '0);
    chk("rst aesA", a1, '0);
    chk("rst aesKeyAssist", 128'(ka1), 128'(0));
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 4; v++) begin
      run_op(0, vt[v].key, vt[v].din, vt[v].enc, out, lat);
      chk($sformatf("vec%0d data", v), out, vt[v].exp);
      chk($sformatf("vec%0d latency", v), 128'(lat),
          128'(vt[v].lat));
    end

    // start held high: one done, re-accept right after it
    @(negedge clk);
    key = K1; din = P1; enc = 1'b1; s1 = 1'b1;
    dones = 0; first = 0; rdy_at_done = 1'b0;
    for (int n = 0; n <= 23; n++) begin
      @(posedge clk); #1;
      if (dn1) begin
        dones++;
        if (first == 0) first = n + 1;
        rdy_at_done = rdy1;
        chk("held data", do1, C1);
      end
    end
    chk("held done count", 128'(dones), 128'(1));
    chk("held latency", 128'(first), 128'(23));
    chk("held ready at done", 128'(rdy_at_done), 128'(1));
    chk("held re-accepted", 128'(rdy1), 128'(0));
    @(negedge clk);
    s1 = 1'b0;
    wait_done(0, 1, lat);
    chk("held second data", do1, C1);

    // reset during key expansion at r=5
    accept(0, K2, P2, 1'b1);
    seen2 = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (ka1 && b1 == 128'd2 && !seen2) begin
        seen2 = 1'b1;
        chk("rk1 fips C.1", a1, R2);
      end
      if (ka1 && b1 == 128'd5) break;
      @(posedge clk); #1;
    end
    chk("reached r=5", b1, 128'd5);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort ready", 128'(rdy1), 128'(1));
    chk("abort done", 128'(dn1), 128'(0));
    chk("abort aesKeyAssist", 128'(ka1), 128'(0));
    chk("abort dataOut", do1, '0);
    @(negedge clk);
    reset = 1'b0;
    run_op(0, K1, P1, 1'b1, out, lat);
    chk("post-abort data", out, C1);
    chk("post-abort latency", 128'(lat), 128'(23));

    // ROUND_CYCLES=3 instance
    accept(1, K1, P1, 1'b1);
    chk("rc3 hold edge0", b3, 128'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rc3 hold edge2", b3, 128'd1);
    @(posedge clk); #1;
    chk("rc3 step edge3", b3, 128'd2);
    chk("rc3 rk1 fips B", a3, R1);
    wait_done(1, 4, lat);
    chk("rc3 data", do3, C1);
    chk("rc3 latency", 128'(lat), 128'(63));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
